// File: rtl/dma_frame_sequencer.sv
// dma_frame_sequencer: frame-level controller for dma_writer_mux.
// Each frame goes capture -> flush -> mux reset. Completed frames rotate through
// a ring of NBUF banks that the host drains with done_ack. Drop and flush-timeout
// conditions raise sticky error flags.
//
// Handshakes: frame_start/frame_end are single-cycle pulses already synchronised
// to c. mux_flush is held high until mux_flush_complete is seen, or until the
// flush timeout expires. done_valid/done_ack is a valid/ack pair: a bank is
// consumed on any cycle where done_valid and done_ack are both high. done_ack
// while done_valid is low has no effect.
module dma_frame_sequencer #(
   parameter int NBUF    = 4,
   parameter int BW      = 2,
   parameter int RST_CYC = 8,
   parameter int TW      = 24,
   parameter logic [TW-1:0] TIMEOUT = 24'hFFFFFF
) (
   input  logic          c,
   input  logic          rst_n,
   input  logic          en,
   input  logic          frame_start,
   input  logic          frame_end,
   output logic          mux_rst,
   output logic          mux_flush,
   input  logic          mux_flush_complete,
   output logic [BW-1:0] bank,
   output logic          done_valid,
   output logic [BW-1:0] done_bank,
   input  logic          done_ack,
   output logic [15:0]   frame_cnt,
   output logic          busy,
   output logic          drop_err,
   output logic          timeout_err,
   input  logic          err_clr,
   output logic [1:0]    state_dbg
);

   typedef enum logic [1:0] {
      ST_RST   = 2'd0,
      ST_IDLE  = 2'd1,
      ST_CAPT  = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   localparam logic [7:0]    RST_LAST = 8'(RST_CYC - 1);
   localparam logic [BW:0]   FULL     = (BW+1)'(NBUF);
   localparam logic [TW-1:0] TMO_LAST = TIMEOUT - {{(TW-1){1'b0}}, 1'b1};

   state_t        state, state_next;
   logic [7:0]    rst_cnt;
   logic [TW-1:0] tmo_cnt;
   logic          commit;
   logic [BW-1:0] wr_bank, rd_bank;
   logic [BW:0]   filled;

   logic rst_done, flush_ok, flush_tmo, drop;
   logic commit_do, ack_do;

   // State register; reset parks the machine in RST so the mux is reset too.
   always_ff @(posedge c) begin
      if (!rst_n) state <= ST_RST;
      else        state <= state_next;
   end

   // Next-state decode plus the single-cycle events that drive the datapath.
   always_comb begin
      state_next = state;
      rst_done   = 1'b0;
      flush_ok   = 1'b0;
      flush_tmo  = 1'b0;
      drop       = 1'b0;
      case (state)
         ST_RST: begin
            if (frame_start) drop = 1'b1;
            if (rst_cnt == RST_LAST) begin
               state_next = ST_IDLE;
               rst_done   = 1'b1;
            end
         end
         ST_IDLE: begin
            // en gates acceptance only; a disabled host sees no drop errors.
            if (frame_start && en) begin
               if (filled != FULL) state_next = ST_CAPT;
               else                drop       = 1'b1;
            end
         end
         ST_CAPT: begin
            if (frame_start) drop = 1'b1;
            if (frame_end) state_next = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (frame_start) drop = 1'b1;
            // A completion in the same cycle as the timeout still commits.
            if (mux_flush_complete) begin
               state_next = ST_RST;
               flush_ok   = 1'b1;
            end else if (tmo_cnt == TMO_LAST) begin
               state_next = ST_RST;
               flush_tmo  = 1'b1;
            end
         end
         default: state_next = ST_RST;
      endcase
   end

   assign commit_do = rst_done & commit;
   assign ack_do    = done_ack & done_valid;

   // Counters, ring pointers and sticky error flags.
   always_ff @(posedge c) begin
      if (!rst_n) begin
         rst_cnt     <= '0;
         tmo_cnt     <= '0;
         commit      <= 1'b0;
         wr_bank     <= '0;
         rd_bank     <= '0;
         filled      <= '0;
         frame_cnt   <= '0;
         drop_err    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         rst_cnt <= (state == ST_RST && !rst_done) ? rst_cnt + 8'd1 : 8'd0;
         // Counts only while flushing, so it starts at zero on every FLUSH entry.
         tmo_cnt <= (state == ST_FLUSH) ? tmo_cnt + {{(TW-1){1'b0}}, 1'b1} : '0;
         if (flush_ok)      commit <= 1'b1;
         else if (rst_done) commit <= 1'b0;
         if (commit_do) begin
            wr_bank   <= wr_bank + 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
         end
         if (ack_do) rd_bank <= rd_bank + 1'b1;
         case ({commit_do, ack_do})
            2'b10:   filled <= filled + 1'b1;
            2'b01:   filled <= filled - 1'b1;
            default: filled <= filled;
         endcase
         if (err_clr)   drop_err <= 1'b0;
         else if (drop) drop_err <= 1'b1;
         if (err_clr)        timeout_err <= 1'b0;
         else if (flush_tmo) timeout_err <= 1'b1;
      end
   end

   assign mux_rst    = (state == ST_RST);
   assign mux_flush  = (state == ST_FLUSH);
   assign busy       = (state != ST_IDLE);
   assign bank       = wr_bank;
   assign done_valid = (filled != '0);
   assign done_bank  = rd_bank;
   assign state_dbg  = state;

endmodule

// File: tb/tb_dma_frame_sequencer.sv
// Directed bench for dma_frame_sequencer with a 100-cycle flush timeout.
module tb_dma_frame_sequencer;

   logic        c = 1'b0;
   logic        rst_n, en, frame_start, frame_end, mux_flush_complete, done_ack, err_clr;
   logic        mux_rst, mux_flush, done_valid, busy, drop_err, timeout_err;
   logic [1:0]  bank, done_bank, state_dbg;
   logic [15:0] frame_cnt;

   int checks = 0;
   int errors = 0;
   int flen, rlen, n;

   dma_frame_sequencer #(
      .NBUF(4), .BW(2), .RST_CYC(8), .TW(24), .TIMEOUT(24'd100)
   ) dut (
      .c(c), .rst_n(rst_n), .en(en), .frame_start(frame_start), .frame_end(frame_end),
      .mux_rst(mux_rst), .mux_flush(mux_flush), .mux_flush_complete(mux_flush_complete),
      .bank(bank), .done_valid(done_valid), .done_bank(done_bank), .done_ack(done_ack),
      .frame_cnt(frame_cnt), .busy(busy), .drop_err(drop_err), .timeout_err(timeout_err),
      .err_clr(err_clr), .state_dbg(state_dbg)
   );

   // Clock
   always #5 c = ~c;

   task automatic tick();
      @(posedge c);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, want);
      end
   endtask

   // Count remaining mux_rst cycles, bounded.
   task automatic wait_rst(output int cnt);
      cnt = 0;
      while (mux_rst && cnt < 100) begin
         cnt++;
         tick();
      end
   endtask

   // Full frame; flush_complete arrives so that FLUSH lasts dly cycles.
   task automatic run_frame(input int dly, output int fl, output int rl);
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      frame_end = 1'b1; tick(); frame_end = 1'b0;
      fl = 0;
      repeat (dly - 1) begin
         if (mux_flush) fl++;
         tick();
      end
      if (mux_flush) fl++;
      mux_flush_complete = 1'b1; tick(); mux_flush_complete = 1'b0;
      wait_rst(rl);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; frame_start = 1'b0; frame_end = 1'b0;
      mux_flush_complete = 1'b0; done_ack = 1'b0; err_clr = 1'b0;

      // 1: reset
      repeat (3) tick();
      chk("rst_mux_rst", mux_rst, 1);
      chk("rst_mux_flush", mux_flush, 0);
      chk("rst_state", state_dbg, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      rst_n = 1'b1;
      wait_rst(rlen);
      chk("rst_len", rlen, 8);
      chk("idle_busy", busy, 0);
      chk("idle_bank", bank, 0);
      chk("idle_done_valid", done_valid, 0);

      // en low: frame_start ignored without error
      en = 1'b0; frame_start = 1'b1; tick(); frame_start = 1'b0;
      chk("en_off_busy", busy, 0);
      chk("en_off_drop", drop_err, 0);
      en = 1'b1;

      // 2: one frame, 50-cycle flush; en drops mid-frame
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      chk("capt_state", state_dbg, 2);
      en = 1'b0;
      frame_end = 1'b1; tick(); frame_end = 1'b0;
      chk("flush_latency", mux_flush, 1);
      flen = 1;
      repeat (49) begin
         tick();
         if (mux_flush) flen++;
      end
      mux_flush_complete = 1'b1; tick(); mux_flush_complete = 1'b0;
      chk("flush_len", flen, 50);
      chk("rst_latency", mux_rst, 1);
      chk("bank_hold_in_rst", bank, 0);
      wait_rst(rlen);
      en = 1'b1;
      chk("frame_rst_len", rlen, 8);
      chk("f1_bank", bank, 1);
      chk("f1_done_valid", done_valid, 1);
      chk("f1_done_bank", done_bank, 0);
      chk("f1_frame_cnt", frame_cnt, 1);

      // 3: fill the ring
      repeat (3) run_frame(3, flen, rlen);
      chk("full_bank", bank, 0);
      chk("full_frame_cnt", frame_cnt, 4);
      chk("full_done_bank", done_bank, 0);
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      chk("full_drop_err", drop_err, 1);
      chk("full_busy", busy, 0);
      done_ack = 1'b1; tick(); done_ack = 1'b0;
      chk("ack_done_bank", done_bank, 1);
      run_frame(3, flen, rlen);
      chk("refill_bank", bank, 1);
      chk("refill_frame_cnt", frame_cnt, 5);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("drop_cleared", drop_err, 0);
      for (int i = 0; i < 4; i++) begin
         chk("drain_valid", done_valid, 1);
         chk("drain_bank", done_bank, 32'((1 + i) % 4));
         done_ack = 1'b1; tick(); done_ack = 1'b0;
      end
      chk("drained_valid", done_valid, 0);
      done_ack = 1'b1; tick(); done_ack = 1'b0;
      chk("idle_ack_ignored", done_bank, 1);

      // 4: flush timeout
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      frame_end = 1'b1; tick(); frame_end = 1'b0;
      n = 0;
      while (mux_flush && n < 200) begin
         n++;
         tick();
      end
      chk("tmo_flush_len", n, 100);
      chk("tmo_err", timeout_err, 1);
      wait_rst(rlen);
      chk("tmo_rst_len", rlen, 8);
      chk("tmo_bank", bank, 1);
      chk("tmo_frame_cnt", frame_cnt, 5);
      chk("tmo_done_valid", done_valid, 0);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("tmo_cleared", timeout_err, 0);

      // 5: ack on the commit cycle with one bank pending
      run_frame(3, flen, rlen);
      chk("p5_bank", bank, 2);
      chk("p5_done_bank", done_bank, 1);
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      // err_clr wins over a same-cycle drop
      frame_start = 1'b1; err_clr = 1'b1; tick(); frame_start = 1'b0; err_clr = 1'b0;
      chk("clr_priority", drop_err, 0);
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      chk("capt_drop", drop_err, 1);
      frame_end = 1'b1; tick(); frame_end = 1'b0;
      mux_flush_complete = 1'b1; tick(); mux_flush_complete = 1'b0;
      repeat (7) tick();
      chk("pre_commit_rst", mux_rst, 1);
      done_ack = 1'b1; tick(); done_ack = 1'b0;
      chk("commit_ack_rst", mux_rst, 0);
      chk("commit_ack_valid", done_valid, 1);
      chk("commit_ack_done_bank", done_bank, 2);
      chk("commit_ack_bank", bank, 3);
      chk("commit_ack_frame_cnt", frame_cnt, 7);
      done_ack = 1'b1; tick(); done_ack = 1'b0;
      chk("commit_ack_filled1", done_valid, 0);

      // 6: reset mid-CAPT and mid-FLUSH
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      chk("rcapt_mux_rst", mux_rst, 1);
      chk("rcapt_mux_flush", mux_flush, 0);
      chk("rcapt_bank", bank, 0);
      chk("rcapt_frame_cnt", frame_cnt, 0);
      chk("rcapt_drop", drop_err, 0);
      wait_rst(rlen);
      run_frame(3, flen, rlen);
      chk("rflush_pre_bank", bank, 1);
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      frame_end = 1'b1; tick(); frame_end = 1'b0;
      chk("rflush_in_flush", mux_flush, 1);
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      chk("rflush_mux_flush", mux_flush, 0);
      chk("rflush_mux_rst", mux_rst, 1);
      chk("rflush_bank", bank, 0);
      chk("rflush_frame_cnt", frame_cnt, 0);
      chk("rflush_done_valid", done_valid, 0);
      wait_rst(rlen);
      chk("rflush_rst_len", rlen, 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
